lcd_bus_sequencer: RTL
======================

# lcd_bus_sequencer

Avalon-MM slave that turns processor accesses into correctly timed 8080-style parallel LCD bus cycles (CE/RD/WR/CD plus a 16-bit data bus). It sits between the SOPC interconnect and the LCD connector. Each access stretches through programmable setup, strobe and hold phases under `avs_lcd_waitrequest_n` flow control, so slow LCD controllers work at any system clock.

## Interface
- `SETUP_CYC`, default 2: cycles CE/CD/data are stable before the strobe; legal range 1..255.
- `STROBE_CYC`, default 4: cycles RD or WR is held low; legal range 1..255.
- `HOLD_CYC`, default 2: cycles CE/CD/data are held after the strobe; legal range 1..255.
- `csi_clockreset_clk`  in  1  system clock; all logic is on the rising edge.
- `csi_clockreset_reset`  in  1  asynchronous, active-high reset.
- `avs_lcd_address`  in  1  becomes LCD CD (0 = command/status, 1 = data).
- `avs_lcd_chipselect_n`  in  1  active-low select.
- `avs_lcd_read_n`  in  1  active-low read request.
- `avs_lcd_write_n`  in  1  active-low write request.
- `avs_lcd_writedata`  in  8  write byte.
- `avs_lcd_readdata`  out  8  registered read byte.
- `avs_lcd_waitrequest_n`  out  1  low = stall the master.
- `LCD_DATA`  inout  16  LCD bus; drives {8'h00, wdata} during write cycles, otherwise Z.
- `LCD_CTRL`  out  4  bits: [0] CE_n, [1] RD_n, [2] WR_n, [3] CD.
- `LCD_BUF_DIR`  out  1  level-shifter direction; 0 = FPGA drives, 1 = LCD drives or idle.
- `LCD_BUSY`  in  1  LCD busy flag, active-high. Present only with `LCD_BUSY_WAIT_EN`.

## Operation
- A request is `chipselect_n==0` with `read_n==0` or `write_n==0`. If both are low, the access is a write.
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE:
  - On a request, latch address, direction and writedata, load the phase counter with `SETUP_CYC-1`, and go to SETUP.
- SETUP:
  - CE_n=0, CD=latched address.
  - For writes: output enable on, BUF_DIR=0.
  - Leave when the counter reaches 0; load `STROBE_CYC-1` and go to STROBE.
- STROBE:
  - RD_n=0 for a read, or WR_n=0 for a write.
  - On the last STROBE cycle, sample `LCD_DATA[7:0]` into `avs_lcd_readdata` (reads only).
  - Load `HOLD_CYC-1` and go to HOLD.
- HOLD:
  - Strobes high; CE_n, CD and the write data are held.
  - At count 0 go to DONE.
- DONE:
  - CE_n=1, output enable off, BUF_DIR=1.
  - Complete the Avalon transfer, then go to IDLE.
- `avs_lcd_waitrequest_n` is combinational:
  - 1 in DONE.
  - 1 in IDLE with no request.
  - 0 otherwise, including the IDLE cycle in which a request arrives.
- `LCD_CTRL`, `LCD_BUF_DIR` and the data output enable are registered and decoded from the next state, so they are glitch-free.
- `avs_lcd_readdata` holds its value until the next read samples.
- Master inputs that change after the IDLE latch cycle are ignored until DONE.

## Timing
- Reset values:
  - state=IDLE, `LCD_CTRL`=4'b0111, `LCD_BUF_DIR`=1.
  - `LCD_DATA`=Z, `avs_lcd_readdata`=8'h00.
  - `avs_lcd_waitrequest_n`=1, forced 1 while reset is asserted.
- Reset asserted mid-cycle: controls go inactive and the bus goes Z immediately (asynchronous). The cycle is not completed.
- With the request first seen at edge 0:
  - CE_n falls after edge 0.
  - The strobe falls after edge `SETUP_CYC`.
  - The strobe rises after edge `SETUP_CYC+STROBE_CYC`.
  - CE_n rises after edge `SETUP_CYC+STROBE_CYC+HOLD_CYC`, the entry to DONE.
- `waitrequest_n` is high in DONE. Total latency = `SETUP_CYC+STROBE_CYC+HOLD_CYC+1` cycles.
- For a back-to-back request, the IDLE cycle after DONE is the earliest point a new request is latched. CE_n is high for at least 2 cycles between accesses.
- The phase counter is 8 bits and never wraps: it is reloaded on every state entry.

## Configuration
- `LCD_BUSY_WAIT_EN` defined:
  - The `LCD_BUSY` port exists and is synchronized through 2 flops.
  - SETUP does not advance to STROBE while the synchronized busy is 1, even when the counter is 0. The counter holds at 0.
  - `waitrequest_n` stays low for the whole wait.
- `LCD_BUSY_WAIT_EN` undefined: no `LCD_BUSY` port, and SETUP lasts exactly `SETUP_CYC` cycles.

## Test plan
- Reset check: assert reset → `LCD_CTRL`=0111, `BUF_DIR`=1, `LCD_DATA`=Z, `readdata`=00, `waitrequest_n`=1.
- Write, defaults (2/4/2): write 8'hA5 to address 1 → CE_n low for 8 cycles, WR_n low for cycles 3..6, `LCD_DATA`=16'h00A5, CD=1, `BUF_DIR`=0, `waitrequest_n` high on cycle 9 only.
- Read: LCD model drives 8'h3C, read from address 0 → RD_n low for 4 cycles, `readdata`=8'h3C when `waitrequest_n` rises, `LCD_DATA` never driven by the DUT.
- Simultaneous read_n and write_n low with 8'h11 → a write cycle occurs and RD_n stays high.
- Back-to-back writes 8'h01 then 8'h02 → two distinct CE_n pulses separated by at least 2 high cycles, with data in order.
- Reset mid-STROBE of a write → WR_n and CE_n go high and `LCD_DATA` goes Z asynchronously. The next access runs a normal full cycle.
- (`LCD_BUSY_WAIT_EN`) `LCD_BUSY` held high for 10 cycles during a write → WR_n falls 2 sync cycles after busy drops, and `waitrequest_n` stays low throughout.

Source files
------------

// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that stretches each access into a timed 8080-style LCD bus cycle.
// Define LCD_BUSY_WAIT_EN to add the LCD_BUSY input that stalls the cycle before its strobe.
module lcd_bus_sequencer #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        csi_clockreset_clk,
  input  logic        csi_clockreset_reset,
  input  logic        avs_lcd_address,
  input  logic        avs_lcd_chipselect_n,
  input  logic        avs_lcd_read_n,
  input  logic        avs_lcd_write_n,
  input  logic [7:0]  avs_lcd_writedata,
  output logic [7:0]  avs_lcd_readdata,
  output logic        avs_lcd_waitrequest_n,
  inout  wire  [15:0] LCD_DATA,
  output logic [3:0]  LCD_CTRL,
  output logic        LCD_BUF_DIR
`ifdef LCD_BUSY_WAIT_EN
  ,
  input  logic        LCD_BUSY
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYC - 1);

  logic       clk;
  logic       rst;
  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic       cnt_zero;
  logic       req;
  logic       req_write;
  logic       lat_write;
  logic       lat_cd;
  logic [7:0] lat_wdata;
  logic       eff_write;
  logic       eff_cd;
  logic       active_nxt;
  logic       busy_stall;
  logic [7:0] readdata_q;
  logic [3:0] ctrl_q;
  logic       buf_dir_q;
  logic       oe_q;

  assign clk = csi_clockreset_clk;
  assign rst = csi_clockreset_reset;

`ifdef LCD_BUSY_WAIT_EN
  logic busy_meta;
  logic busy_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      busy_meta <= LCD_BUSY;
      busy_sync <= busy_meta;
    end
  end

  assign busy_stall = busy_sync;
`else
  assign busy_stall = 1'b0;
`endif

  // In IDLE the request inputs have not been latched yet, so the output decode
  // looks at them directly; in every later state it uses the latched copy.
  always_comb begin
    req        = !avs_lcd_chipselect_n && (!avs_lcd_read_n || !avs_lcd_write_n);
    req_write  = !avs_lcd_write_n;
    cnt_zero   = (cnt == 8'd0);
    eff_write  = (state == IDLE) ? req_write : lat_write;
    eff_cd     = (state == IDLE) ? avs_lcd_address : lat_cd;
    nxt        = state;
    case (state)
      IDLE:    if (req) nxt = SETUP;
      SETUP:   if (cnt_zero && !busy_stall) nxt = STROBE;
      STROBE:  if (cnt_zero) nxt = HOLD;
      HOLD:    if (cnt_zero) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    active_nxt = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
  end

  // Bus controls are decoded from the next state and registered, so each pin
  // changes exactly once per edge with no combinational glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      lat_write  <= 1'b0;
      lat_cd     <= 1'b0;
      lat_wdata  <= 8'h00;
      readdata_q <= 8'h00;
      ctrl_q     <= 4'b0111;
      buf_dir_q  <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (req) begin
            lat_write <= req_write;
            lat_cd    <= avs_lcd_address;
            lat_wdata <= avs_lcd_writedata;
            cnt       <= SETUP_LOAD;
          end
        end
        SETUP: begin
          if (!cnt_zero) begin
            cnt <= cnt - 8'd1;
          end else if (nxt == STROBE) begin
            cnt <= STROBE_LOAD;
          end
        end
        STROBE: begin
          if (!cnt_zero) begin
            cnt <= cnt - 8'd1;
          end else begin
            cnt <= HOLD_LOAD;
            if (!lat_write) begin
              readdata_q <= LCD_DATA[7:0];
            end
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
        end
      endcase
      ctrl_q[0] <= !active_nxt;
      ctrl_q[1] <= !((nxt == STROBE) && !eff_write);
      ctrl_q[2] <= !((nxt == STROBE) && eff_write);
      ctrl_q[3] <= active_nxt && eff_cd;
      oe_q      <= active_nxt && eff_write;
      buf_dir_q <= !(active_nxt && eff_write);
    end
  end

  assign avs_lcd_waitrequest_n = rst || (state == DONE) || ((state == IDLE) && !req);
  assign avs_lcd_readdata      = readdata_q;
  assign LCD_CTRL              = ctrl_q;
  assign LCD_BUF_DIR           = buf_dir_q;
  assign LCD_DATA              = oe_q ? {8'h00, lat_wdata} : 16'hzzzz;

endmodule
